muldiv_unit: RTL

- Parametrised sequential multiply/divide unit that replaces the separate fixed-width mult and div blocks feeding the Hi/Lo registers of the multicycle datapath.
- One iterative engine, radix-2, one bit per cycle. Covers signed and unsigned multiply and divide behind a start/busy/done handshake, with divide-by-zero detection.
- The control FSM waits on done before loading Hi/Lo.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bus between the multicycle control path and the
// iterative multiply/divide engine.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide engine: one bit per cycle on operand
// magnitudes, sign restored in a final FIX cycle before hi/lo are written.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     bmag_q, bmag_d;
  logic                 div_q, div_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    sgn_op;
  logic [WIDTH:0]          rem_sh, trial, sum;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic en);
    logic [WIDTH-1:0] u;
    u = $unsigned(v);
    return (en && v[WIDTH-1]) ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign a_s    = bus.a;
  assign b_s    = bus.b;
  assign sgn_op = ~bus.op[0];

  // Restoring-divide trial subtract on a WIDTH+1 bit partial remainder
  assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, bmag_q};
  // Shift-add: upper half plus multiplicand, carry kept for the right shift
  assign sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_d  = bus.op[1];
          negq_d = sgn_op & (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
          negr_d = sgn_op & a_s[WIDTH-1];
          acc_d  = {{WIDTH{1'b0}}, mag(a_s, sgn_op)};
          bmag_d = mag(b_s, sgn_op);
          cnt_d  = CNT_W'(WIDTH);
          dz_d   = 1'b0;
          if (bus.op[1] && (bus.b == '0)) begin
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (div_q) begin
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          lo_d = fix_sign(acc_q[WIDTH-1:0], negq_q);
          hi_d = fix_sign(acc_q[2*WIDTH-1:WIDTH], negr_q);
        end else begin
          {hi_d, lo_d} = fix_sign2(acc_q, negq_q);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath registers are don't-care outside RUN/FIX, so they carry no reset
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    bmag_q <= bmag_d;
    div_q  <= div_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule
